// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file arbiter: architectural register
// indices, default widths and the access FSM state encoding.
package regfile_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_REG_W  = 4;
  localparam int NUM_REGS   = 14;

  localparam int PC   = 0;
  localparam int SP   = 1;
  localparam int LR   = 2;
  localparam int SR   = 3;
  localparam int R0   = 4;
  localparam int R1   = 5;
  localparam int R2   = 6;
  localparam int R3   = 7;
  localparam int R4   = 8;
  localparam int R5   = 9;
  localparam int R6   = 10;
  localparam int R7   = 11;
  localparam int R8   = 12;
  localparam int ADDR = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin pick: a lone request wins outright, a tie goes
// to the requester that was not granted last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       winner
);

  always_comb begin
    winner = 1'b0;
    if (req[0] && req[1]) winner = ~last_grant;
    else                  winner = req[1];
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Arbitrates two requesters onto a single-port register file with a
// three-cycle IDLE/ACC/RESP access; every output is registered.
module regfile_arbiter #(
  parameter int DATA_W   = regfile_pkg::DEF_DATA_W,
  parameter int REG_W    = regfile_pkg::DEF_REG_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [REG_W-1:0]  m0_reg,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [REG_W-1:0]  m1_reg,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic [REG_W-1:0]  rf_register,
  output logic              rf_write,
  output logic [DATA_W-1:0] rf_data_in,
  input  logic [DATA_W-1:0] rf_data_out
);

  import regfile_pkg::*;

  state_t            state;
  logic [1:0]        req_vec;
  logic              win;
  logic              last_grant;
  logic              sel_we;
  logic              sel_legal;
  logic [REG_W-1:0]  sel_reg;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] rsp_data;
  logic              cap_win;
  logic              cap_we;
  logic              cap_legal;

  assign req_vec = {m1_req, m0_req};

  rr_arb2 u_rr_arb2 (
    .req        (req_vec),
    .last_grant (last_grant),
    .winner     (win)
  );

  always_comb begin
    sel_we    = win ? m1_we    : m0_we;
    sel_reg   = win ? m1_reg   : m0_reg;
    sel_wdata = win ? m1_wdata : m0_wdata;
    sel_legal = (32'(sel_reg) < 32'(NUM_REGS));
    // Writes and illegal indices acknowledge with zero data.
    rsp_data  = (!cap_we && cap_legal) ? rf_data_out : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      cap_win     <= 1'b0;
      cap_we      <= 1'b0;
      cap_legal   <= 1'b0;
      m0_gnt      <= 1'b0;
      m1_gnt      <= 1'b0;
      m0_rvalid   <= 1'b0;
      m1_rvalid   <= 1'b0;
      m0_err      <= 1'b0;
      m1_err      <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
      rf_register <= '0;
      rf_write    <= 1'b0;
      rf_data_in  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_vec) begin
            state       <= ACC;
            cap_win     <= win;
            cap_we      <= sel_we;
            cap_legal   <= sel_legal;
            last_grant  <= win;
            rf_register <= sel_reg;
            rf_data_in  <= sel_wdata;
            rf_write    <= sel_we & sel_legal;
            m0_gnt      <= ~win;
            m1_gnt      <= win;
          end
        end
        ACC: begin
          // rf_data_out is settled from rf_register, sampled at end of ACC.
          state    <= RESP;
          m0_gnt   <= 1'b0;
          m1_gnt   <= 1'b0;
          rf_write <= 1'b0;
          if (cap_win) begin
            m1_rvalid <= 1'b1;
            m1_rdata  <= rsp_data;
            m1_err    <= ~cap_legal;
          end else begin
            m0_rvalid <= 1'b1;
            m0_rdata  <= rsp_data;
            m0_err    <= ~cap_legal;
          end
        end
        RESP: begin
          state     <= IDLE;
          m0_rvalid <= 1'b0;
          m1_rvalid <= 1'b0;
          m0_err    <= 1'b0;
          m1_err    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 Parameter DATA_W, 16, register data width.
REQ-002 Parameter REG_W, 4, register index width.
REQ-003 Parameter NUM_REGS, 14, count of legal indices (0..NUM_REGS-1).
REQ-004 clk  in  1  single clock; all state SHALL change only on its rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 m0_req  in  1  requester 0 access request; fields held stable while high.
REQ-007 m0_we  in  1  1 = write, 0 = read.
REQ-008 m0_reg  in  REG_W  target register index.
REQ-009 m0_wdata  in  DATA_W  write data.
REQ-010 m0_gnt  out  1  one-cycle pulse: request accepted and issued.
REQ-011 m0_rvalid  out  1  one-cycle pulse: m0_rdata/m0_err valid.
REQ-012 m0_rdata  out  DATA_W  read result.
REQ-013 m0_err  out  1  illegal-index flag, qualified by m0_rvalid.
REQ-014 m1_req, m1_we, m1_reg, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err SHALL mirror REQ-006..REQ-013 for requester 1.
REQ-015 rf_register  out  REG_W  register-file index select.
REQ-016 rf_write  out  1  register-file write enable (level-sensitive target).
REQ-017 rf_data_in  out  DATA_W  register-file write data.
REQ-018 rf_data_out  in  DATA_W  register-file read data, combinational from rf_register.

Function
REQ-019 FSM states: IDLE, ACC, RESP; IDLE->ACC when any req sampled high, ACC->RESP always, RESP->IDLE always.
REQ-020 In IDLE the winner SHALL be chosen, its we/reg/wdata captured, and its gnt asserted in the following (ACC) cycle.
REQ-021 Arbitration SHALL be round-robin: single request wins; with both, the requester not granted last wins; last_grant resets to 1 (m0 wins first tie).
REQ-022 All rf_* and m*_ outputs SHALL be registered.
REQ-023 rf_register SHALL change only on entry to ACC and hold through ACC and RESP, so it is stable whenever rf_write changes.
REQ-024 rf_write SHALL be high for exactly the ACC cycle of a legal write; otherwise 0.
REQ-025 rf_data_in SHALL equal captured wdata during ACC; value outside ACC is don't-care but SHALL not glitch mid-cycle.
REQ-026 Read: rf_data_out SHALL be sampled at end of ACC; winner's rvalid=1 with rdata in RESP (latency: req sampled cycle N -> gnt N+1 -> rvalid N+2).
REQ-027 Write: winner's rvalid=1 in RESP with err=0 and rdata=0x0000 (write acknowledge).
REQ-028 Index >= NUM_REGS: gnt issued, rf_write kept 0, rvalid in RESP with err=1, rdata=0x0000.
REQ-029 Loser's req SHALL be left pending, unaffected; it is re-arbitrated in next IDLE.
REQ-030 Requesters drop req the cycle after gnt; req high in IDLE is always a new request; peak throughput one access per 3 cycles.
REQ-031 gnt/rvalid of the non-winner SHALL be 0; at most one gnt and one rvalid high per cycle.

Reset
REQ-032 rst_n low at a rising edge SHALL force state IDLE, last_grant=1, all gnt/rvalid/err/rf_write=0, rdata/rf_register/rf_data_in=0.
REQ-033 Reset during ACC or RESP SHALL abort the access with no response pulse; rf_write SHALL be 0 from the next edge.

Structure
REQ-034 Package regfile_pkg SHALL hold register index constants (PC=0..ADDR=13), NUM_REGS, DATA_W/REG_W defaults, and the FSM state enum.
REQ-035 Two-input round-robin pick logic SHALL be a sub-module rr_arb2 (inputs req[1:0], last_grant; output winner); the rest stays in regfile_arbiter.

Verification
REQ-036 m0 write reg 3 = 0xBEEF -> m0_gnt at N+1, rf_register=3 and rf_write=1 only in N+1, m0_rvalid at N+2 with err=0.
REQ-037 m1 read reg 3 after REQ-036 (model regfile) -> m1_rvalid at N+2 with m1_rdata=0xBEEF.
REQ-038 Both req held continuously after reset -> grants alternate m0,m1,m0,m1 every 3 cycles.
REQ-039 m0 write to index 14 -> m0_gnt pulses, rf_write stays 0, m0_rvalid with m0_err=1, rdata=0x0000.
REQ-040 rst_n low during ACC of a write -> rf_write 0 after that edge, no rvalid, next tie grants m0.
